// File: rtl/oled_string_writer.sv
// oled_string_writer: 64-character frame buffer (4 pages x 16 columns) streamed to the
// OLED controller's character port with a valid/done handshake. Frames after the first
// are preceded by an updateString re-address pulse and a settle gap.
module oled_string_writer #(
    parameter int unsigned NUM_CHARS     = 64,
    parameter int unsigned SETTLE_CYCLES = 2048,
    parameter logic [6:0]  BLANK_CHAR    = 7'h20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wrEn,
    input  logic [5:0] wrAddr,
    input  logic [6:0] wrChar,
    input  logic       refresh,
    output logic       ready,
    output logic       frameBusy,
    output logic       frameDone,
    output logic [6:0] sendData,
    output logic       sendDataValid,
    input  logic       sendDone,
    output logic       updateString
);

    localparam logic [5:0] LastIdx = 6'(NUM_CHARS - 1);
    localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StUpdate,
        StSettle,
        StFetch,
        StPresent,
        StRelease
    } stateT;

    stateT              state;
    logic [5:0]         idx;
    logic [SettleW-1:0] settleCnt;
    logic               pending;
    logic               firstFrame;
    logic [6:0]         rdData;
    logic [6:0]         mem [NUM_CHARS];

    logic       acceptWr;
    logic       memWe;
    logic [5:0] memAddr;
    logic [6:0] memData;

    assign acceptWr = wrEn && ready;

    // Buffer write port: the clear sweep owns the port, user writes only while ready
    always_comb begin
        memWe   = 1'b0;
        memAddr = wrAddr;
        memData = wrChar;
        if (state == StClear) begin
            memWe   = 1'b1;
            memAddr = idx;
            memData = BLANK_CHAR;
        end else if (acceptWr) begin
            memWe = 1'b1;
        end
    end

    // Character RAM with one-cycle synchronous read issued from FETCH
    always_ff @(posedge clock) begin
        if (memWe) begin
            mem[memAddr] <= memData;
        end
        if (state == StFetch) begin
            rdData <= mem[idx];
        end
    end

    // Frame sequencer with registered handshake and status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= StClear;
            idx           <= '0;
            settleCnt     <= '0;
            pending       <= 1'b0;
            firstFrame    <= 1'b0;
            ready         <= 1'b0;
            frameBusy     <= 1'b0;
            frameDone     <= 1'b0;
            sendData      <= '0;
            sendDataValid <= 1'b0;
            updateString  <= 1'b0;
        end else begin
            frameDone    <= 1'b0;
            updateString <= 1'b0;
            if (acceptWr || refresh) begin
                pending <= 1'b1;
            end
            unique case (state)
                StClear: begin
                    if (idx == LastIdx) begin
                        idx        <= '0;
                        pending    <= 1'b1;
                        firstFrame <= 1'b1;
                        ready      <= 1'b1;
                        state      <= StIdle;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                StIdle: begin
                    idx <= '0;
                    if (pending) begin
                        // A write or refresh landing in this very cycle must survive
                        pending   <= acceptWr || refresh;
                        frameBusy <= 1'b1;
                        if (firstFrame) begin
                            // Controller init already addressed page 0, column 0
                            state <= StFetch;
                        end else begin
                            updateString <= 1'b1;
                            state        <= StUpdate;
                        end
                    end
                end
                StUpdate: begin
                    settleCnt <= '0;
                    state     <= StSettle;
                end
                StSettle: begin
                    if (settleCnt == SettleLast) begin
                        state <= StFetch;
                    end else begin
                        settleCnt <= settleCnt + 1'b1;
                    end
                end
                StFetch: begin
                    state <= StPresent;
                end
                StPresent: begin
                    if (!sendDataValid) begin
                        // Never raise valid into a still-high acknowledge
                        if (!sendDone) begin
                            sendData      <= rdData;
                            sendDataValid <= 1'b1;
                        end
                    end else if (sendDone) begin
                        sendDataValid <= 1'b0;
                        state         <= StRelease;
                    end
                end
                StRelease: begin
                    if (!sendDone) begin
                        if (idx == LastIdx) begin
                            frameDone  <= 1'b1;
                            firstFrame <= 1'b0;
                            frameBusy  <= 1'b0;
                            state      <= StIdle;
                        end else begin
                            idx   <= idx + 6'd1;
                            state <= StFetch;
                        end
                    end
                end
                default: begin
                    state <= StClear;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_string_writer.sv
// tb_oled_string_writer: drives oled_string_writer with a behavioural OLED controller,
// scenario stimulus and randomized buffer writes, checking every streamed character
// against a reference image of the buffer.
module tb_oled_string_writer;

    localparam int unsigned SettleCycles = 2048;

    logic       clock;
    logic       reset;
    logic       wrEn;
    logic [5:0] wrAddr;
    logic [6:0] wrChar;
    logic       refresh;
    logic       ready;
    logic       frameBusy;
    logic       frameDone;
    logic [6:0] sendData;
    logic       sendDataValid;
    logic       sendDone;
    logic       updateString;

    oled_string_writer #(
        .NUM_CHARS    (64),
        .SETTLE_CYCLES(SettleCycles),
        .BLANK_CHAR   (7'h20)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wrEn         (wrEn),
        .wrAddr       (wrAddr),
        .wrChar       (wrChar),
        .refresh      (refresh),
        .ready        (ready),
        .frameBusy    (frameBusy),
        .frameDone    (frameDone),
        .sendData     (sendData),
        .sendDataValid(sendDataValid),
        .sendDone     (sendDone),
        .updateString (updateString)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int numCompared   = 0;
    int numMismatched = 0;

    // Reference image of the buffer, owned by the stimulus
    logic [6:0] refMem [64];

    // Monitor state
    logic [6:0] lastFrame [64];
    int         charCount  = 0;
    int         frameCount = 0;
    int         updCount   = 0;
    int         cycleNo    = 0;
    int         updCycle   = 0;
    int         updWidth   = 0;
    int         lastDoneCycle  = 0;
    int         lastWriteCycle = 0;
    bit         settleArmed = 0;
    logic       prevValid = 0;
    logic       prevDone  = 0;
    logic [6:0] prevData  = '0;

    // Controller model state
    bit ctrlSlow  = 0;
    int ctrlPhase = 0;
    int ctrlCnt   = 0;

    task automatic checkValue(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // OLED controller: acknowledge each valid after a delay, hold sendDone for 3 cycles
    initial begin : ctrlModel
        sendDone = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                sendDone  = 1'b0;
                ctrlPhase = 0;
            end else begin
                case (ctrlPhase)
                    0: if (sendDataValid) begin
                        ctrlCnt   = ctrlSlow ? 80 : int'($urandom_range(0, 5));
                        ctrlPhase = 1;
                    end
                    1: if (ctrlCnt == 0) begin
                        sendDone  = 1'b1;
                        ctrlCnt   = 3;
                        ctrlPhase = 2;
                    end else begin
                        ctrlCnt--;
                    end
                    default: begin
                        ctrlCnt--;
                        if (ctrlCnt == 0) begin
                            sendDone  = 1'b0;
                            ctrlPhase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Stream monitor: per-character checks, handshake timing, frame and pulse bookkeeping
    initial begin : monitor
        forever begin
            @(posedge clock);
            #1;
            cycleNo++;
            if (reset) begin
                charCount   = 0;
                settleArmed = 0;
                updWidth    = 0;
                prevValid   = 1'b0;
                prevDone    = 1'b0;
            end else begin
                if (sendDataValid && !prevValid) begin
                    checkValue("validWhileDone", sendDone, 0);
                    if (settleArmed) begin
                        checkValue("settleGap", (cycleNo - updCycle >= SettleCycles) &&
                                   (cycleNo - updCycle <= SettleCycles + 4), 1);
                        settleArmed = 0;
                    end
                    if (charCount < 64) begin
                        checkValue($sformatf("char%0d", charCount), sendData,
                                   refMem[charCount]);
                        lastFrame[charCount] = sendData;
                    end
                    charCount++;
                end
                if (sendDataValid && prevValid) begin
                    checkValue("dataStable", sendData, prevData);
                end
                if (prevValid && sendDone && !prevDone) begin
                    checkValue("validDropAfterDone", sendDataValid, 0);
                end
                if (frameDone) begin
                    checkValue("frameLen", charCount, 64);
                    frameCount++;
                    charCount     = 0;
                    lastDoneCycle = cycleNo;
                end
                if (updateString) begin
                    if (updWidth == 0) begin
                        updCount++;
                        updCycle    = cycleNo;
                        settleArmed = 1;
                    end
                    updWidth++;
                end else if (updWidth != 0) begin
                    checkValue("updWidth", updWidth, 1);
                    updWidth = 0;
                end
                prevValid = sendDataValid;
                prevDone  = sendDone;
                prevData  = sendData;
            end
        end
    end

    task automatic resetDut();
        int readyLow   = 0;
        int firstValid = 0;
        reset = 1'b1;
        for (int i = 0; i < 64; i++) refMem[i] = 7'h20;
        @(posedge clock);
        #1;
        checkValue("rstValid", sendDataValid, 0);
        checkValue("rstData", sendData, 0);
        checkValue("rstUpd", updateString, 0);
        checkValue("rstDone", frameDone, 0);
        checkValue("rstBusy", frameBusy, 0);
        checkValue("rstReady", ready, 0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        if (!ready) readyLow++;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clock);
            #1;
            if (n <= 66 && !ready) readyLow++;
            if (sendDataValid) begin
                firstValid = n;
                break;
            end
        end
        checkValue("readyLowCycles", readyLow, 64);
        checkValue("firstValidLatency", firstValid, 67);
    endtask

    // Writes avoid the index whose fetch may coincide with the write edge
    task automatic writeChar(input logic [5:0] addr, input logic [6:0] ch,
                             input bit withRefresh);
        logic [5:0] a;
        @(negedge clock);
        a = addr;
        if (a == 6'(charCount % 64)) a = a + 6'd1;
        wrEn    = 1'b1;
        wrAddr  = a;
        wrChar  = ch;
        refresh = withRefresh;
        refMem[a] = ch;
        lastWriteCycle = cycleNo;
        @(negedge clock);
        wrEn    = 1'b0;
        refresh = 1'b0;
    endtask

    task automatic pulseRefresh();
        @(negedge clock);
        refresh = 1'b1;
        @(negedge clock);
        refresh = 1'b0;
    endtask

    task automatic waitChars(input int n);
        int k = 0;
        while (charCount < n && k < 20000) begin
            @(posedge clock);
            #2;
            k++;
        end
        checkValue($sformatf("reachChar%0d", n), charCount >= n, 1);
    endtask

    task automatic waitFrameDone();
        int k = 0;
        bit seen = 0;
        while (!seen && k < 20000) begin
            @(posedge clock);
            #2;
            seen = frameDone;
            k++;
        end
        checkValue("frameDoneSeen", seen, 1);
    endtask

    task automatic waitQuiet(input string tag);
        int idle = 0;
        for (int n = 0; n < 20000 && idle < 20; n++) begin
            @(posedge clock);
            #2;
            if (!frameBusy && ready && !sendDataValid) idle++;
            else idle = 0;
        end
        checkValue({tag, "Quiet"}, idle >= 20, 1);
    endtask

    task automatic checkImage(input string tag);
        int diffs = 0;
        for (int i = 0; i < 64; i++) begin
            if (lastFrame[i] !== refMem[i]) diffs++;
        end
        checkValue({tag, "Image"}, diffs, 0);
    endtask

    initial begin : watchdog
        #950000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int f0;
        int u0;
        int nw;
        reset   = 1'b1;
        wrEn    = 1'b0;
        wrAddr  = '0;
        wrChar  = '0;
        refresh = 1'b0;

        // Reset, clear and a slow-handshake first frame of blanks
        ctrlSlow = 1;
        f0 = frameCount;
        u0 = updCount;
        resetDut();
        waitQuiet("first");
        checkValue("firstFrames", frameCount - f0, 1);
        checkValue("firstNoUpd", updCount - u0, 0);
        checkImage("first");
        ctrlSlow = 0;

        // Redraw: write 'A' at 17 together with a refresh
        f0 = frameCount;
        u0 = updCount;
        writeChar(6'd17, 7'h41, 1'b1);
        waitQuiet("redraw");
        checkValue("redrawFrames", frameCount - f0, 1);
        checkValue("redrawUpd", updCount - u0, 1);
        checkValue("redrawIdx17", lastFrame[17], 7'h41);

        // Write at index 3 while the frame is past index 40
        f0 = frameCount;
        u0 = updCount;
        pulseRefresh();
        waitChars(41);
        writeChar(6'd3, 7'h42, 1'b0);
        waitQuiet("midWrite");
        checkValue("midWriteFrames", frameCount - f0, 2);
        checkValue("midWriteUpd", updCount - u0, 2);
        checkValue("midWriteIdx3", lastFrame[3], 7'h42);

        // Refresh in the same cycle as frameDone
        f0 = frameCount;
        pulseRefresh();
        waitFrameDone();
        refresh = 1'b1;
        @(posedge clock);
        #2;
        refresh = 1'b0;
        waitQuiet("refAtDone");
        checkValue("refAtDoneFrames", frameCount - f0, 2);

        // Two refreshes inside one frame
        f0 = frameCount;
        pulseRefresh();
        waitChars(10);
        pulseRefresh();
        waitChars(30);
        pulseRefresh();
        waitQuiet("dblRef");
        checkValue("dblRefFrames", frameCount - f0, 2);

        // Randomized writes, idle and mid-frame
        for (int r = 0; r < 4; r++) begin
            f0 = frameCount;
            nw = int'($urandom_range(1, 6));
            if (r % 2 == 1) begin
                pulseRefresh();
                waitChars(int'($urandom_range(5, 50)));
            end
            for (int k = 0; k < nw; k++) begin
                repeat ($urandom_range(0, 30)) @(negedge clock);
                writeChar(6'($urandom_range(0, 63)), 7'($urandom_range(0, 127)),
                          1'($urandom_range(0, 1)));
            end
            waitQuiet($sformatf("rnd%0d", r));
            checkValue("rndFrames", frameCount - f0 >= 1, 1);
            checkValue("rndFrameAfterWrite", lastDoneCycle > lastWriteCycle, 1);
            checkImage($sformatf("rnd%0d", r));
        end

        // Reset while index 20 is being presented
        f0 = frameCount;
        u0 = updCount;
        pulseRefresh();
        waitChars(21);
        f0 = frameCount;
        u0 = updCount;
        resetDut();
        waitQuiet("midReset");
        checkValue("midResetFrames", frameCount - f0, 1);
        checkValue("midResetNoUpd", updCount - u0, 0);
        checkImage("midReset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
